// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, aluop/alusel encodings, FSM states and memory-op decode
package mem_stage_pkg;
  localparam int REG_LEN = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int ADDR_LEN = 32;
  localparam int ALU_OP_LEN = 8;
  localparam int ALU_SEL_LEN = 3;
  localparam logic [ALU_OP_LEN-1:0] OP_NOP = 8'h00;
  localparam logic [ALU_OP_LEN-1:0] OP_ADD = 8'h01;
  localparam logic [ALU_OP_LEN-1:0] OP_LB = 8'h20;
  localparam logic [ALU_OP_LEN-1:0] OP_LH = 8'h21;
  localparam logic [ALU_OP_LEN-1:0] OP_LW = 8'h22;
  localparam logic [ALU_OP_LEN-1:0] OP_LBU = 8'h23;
  localparam logic [ALU_OP_LEN-1:0] OP_LHU = 8'h24;
  localparam logic [ALU_OP_LEN-1:0] OP_SB = 8'h25;
  localparam logic [ALU_OP_LEN-1:0] OP_SH = 8'h26;
  localparam logic [ALU_OP_LEN-1:0] OP_SW = 8'h27;
  localparam logic [ALU_SEL_LEN-1:0] SEL_NOP = 3'd0;
  localparam logic [ALU_SEL_LEN-1:0] SEL_ARITH = 3'd1;
  localparam logic [ALU_SEL_LEN-1:0] SEL_MEM = 3'd3;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, ACCESS, DONE} state_t;
  function automatic logic [2:0] mem_op_bytes(input logic [ALU_OP_LEN-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_SB} ? 3'd1 :
           op inside {OP_LH, OP_LHU, OP_SH} ? 3'd2 :
           op inside {OP_LW, OP_SW} ? 3'd4 : 3'd0;
  endfunction
  function automatic logic is_load_op(input logic [ALU_OP_LEN-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction
endpackage

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: assembles the captured little-endian bytes and sign/zero-extends per load type
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0][7:0]        bytes,
  input  logic [ALU_OP_LEN-1:0]  aluop,
  output logic [REG_LEN-1:0]     data
);
  logic [31:0] w;
  assign w = bytes;
  always_comb data = aluop == OP_LB  ? {{24{w[7]}}, w[7:0]} :
                     aluop == OP_LH  ? {{16{w[15]}}, w[15:0]} :
                     aluop == OP_LBU ? {24'd0, w[7:0]} :
                     aluop == OP_LHU ? {16'd0, w[15:0]} : w;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage serialising loads/stores over a byte-wide arbitrated RAM port
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [REG_LEN-1:0]       in_rd_data,
  input  logic [REG_ADDR_LEN-1:0]  in_rd_addr,
  input  logic                     in_rd_enable,
  input  logic [ALU_OP_LEN-1:0]    in_aluop,
  input  logic [ALU_SEL_LEN-1:0]   in_alusel,
  input  logic [ADDR_LEN-1:0]      in_mem_addr,
  output logic [REG_LEN-1:0]       wb_rd_data,
  output logic [REG_ADDR_LEN-1:0]  wb_rd_addr,
  output logic                     wb_rd_enable,
  output logic                     stall_req,
  output logic                     mem_req,
  input  logic                     mem_gnt,
  output logic [ADDR_LEN-1:0]      mem_a,
  output logic [7:0]               mem_dout,
  output logic                     mem_wr,
  input  logic [7:0]               mem_din
);
  state_t state, state_n;
  logic [2:0] cnt, n;
  logic [ADDR_LEN-1:0] addr;
  logic [REG_LEN-1:0] ext;
  logic [3:0][7:0] bytes;
  logic is_mem, is_ld, is_st, live, access_on, busy;
  assign n = mem_op_bytes(in_aluop);
  assign is_mem = in_alusel == SEL_MEM && n != 3'd0;
  assign is_ld = is_mem && is_load_op(in_aluop);
  assign is_st = is_mem && !is_ld;
  assign live = !rst;
  assign busy = state == WAIT_GNT || state == ACCESS;
  assign access_on = state == ACCESS && cnt < n;
  // loads run one extra count to capture the last byte returned by the RAM
  always_comb begin
    state_n = state == IDLE     ? (is_mem ? WAIT_GNT : IDLE) :
              state == WAIT_GNT ? (mem_gnt ? ACCESS : WAIT_GNT) :
              state == ACCESS   ? (cnt == (is_ld ? n : n - 3'd1) ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      bytes <= '0;
    end else if (rdy) begin
      state <= state_n;
      if (state == IDLE) begin
        addr <= in_mem_addr;
        cnt <= '0;
      end else if (state == ACCESS) cnt <= cnt + 3'd1;
      if (state == ACCESS && is_ld && cnt != 3'd0) bytes[cnt[1:0] - 2'd1] <= mem_din;
    end
  end
  mem_load_ext u_ext (.bytes(bytes), .aluop(in_aluop), .data(ext));
  assign mem_req = live && busy;
  assign stall_req = live && (state == IDLE ? is_mem : busy);
  assign mem_a = live && access_on ? addr + {29'd0, cnt} : '0;
  assign mem_wr = live && rdy && access_on && is_st;
  assign mem_dout = live && access_on && is_st ? 8'(in_rd_data >> {cnt[1:0], 3'b000}) : '0;
  assign wb_rd_addr = live ? in_rd_addr : '0;
  assign wb_rd_data = !live ? '0 : (is_ld && state == DONE) ? ext : in_rd_data;
  assign wb_rd_enable = live && (is_mem ? (state == DONE && is_ld && in_rd_enable) : in_rd_enable);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench with RAM, arbiter and byte-level reference model
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic clk = 0, rst, rdy;
  logic [31:0] in_rd_data, in_mem_addr, wb_rd_data, mem_a;
  logic [4:0] in_rd_addr, wb_rd_addr;
  logic in_rd_enable, wb_rd_enable, stall_req, mem_req, mem_gnt, mem_wr;
  logic [7:0] in_aluop, mem_dout, mem_din;
  logic [2:0] in_alusel;
  int n_tests = 0, n_fail = 0, req_cnt = 0, gnt_delay = 0;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_ram [logic [31:0]];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_rd_data(in_rd_data), .in_rd_addr(in_rd_addr), .in_rd_enable(in_rd_enable),
    .in_aluop(in_aluop), .in_alusel(in_alusel), .in_mem_addr(in_mem_addr),
    .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
    .stall_req(stall_req), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction
  function logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end
  always @(posedge clk) req_cnt <= mem_req ? req_cnt + 1 : 0;
  assign mem_gnt = mem_req && req_cnt >= gnt_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] data,
                       input logic [4:0] rd, input logic en, input logic [31:0] addr);
    in_aluop = op; in_alusel = sel; in_rd_data = data;
    in_rd_addr = rd; in_rd_enable = en; in_mem_addr = addr;
  endtask

  task automatic run_alu(input logic [31:0] data, input logic [4:0] rd, input logic en);
    @(negedge clk);
    rdy = 1;
    drive(OP_ADD, SEL_ARITH, data, rd, en, 32'h0);
    #1;
    check("alu_d", wb_rd_data, data);
    check("alu_a", {27'd0, wb_rd_addr}, {27'd0, rd});
    check("alu_en", {31'd0, wb_rd_enable}, {31'd0, en});
    check("alu_stall", {31'd0, stall_req}, 0);
    check("alu_req", {31'd0, mem_req}, 0);
  endtask

  task automatic run_mem(input logic [7:0] op, input logic [31:0] data, input logic [31:0] addr,
                         input logic [4:0] rd, input logic en, input int d, input bit frz);
    int n, base, exp_done, c, w;
    bit ld, done;
    logic [31:0] v, ev;
    n = op inside {OP_LW, OP_SW} ? 4 : op inside {OP_LH, OP_LHU, OP_SH} ? 2 : 1;
    ld = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    base = 2 + d + (ld ? n + 1 : n);
    exp_done = base + (frz ? 2 : 0);
    v = 0;
    for (int i = 0; i < n; i++) v += 32'(ref_rd(addr + 32'(i))) << (8 * i);
    ev = !ld ? data : op == OP_LB ? (v[7] ? v - 32'h100 : v) :
         op == OP_LH ? (v[15] ? v - 32'h10000 : v) : v;
    if (!ld) for (int i = 0; i < n; i++) ref_ram[addr + 32'(i)] = 8'(data >> (8 * i));
    gnt_delay = d;
    c = 0; w = 0; done = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      rdy = !(frz && (c == 2 + d || c == 3 + d));
      drive(op, SEL_MEM, data, rd, en, addr);
      #1;
      if (!rdy) check("frz_wr", {31'd0, mem_wr}, 0);
      if (mem_wr) begin
        check("st_a", mem_a, addr + 32'(w));
        check("st_d", {24'd0, mem_dout}, {24'd0, 8'(data >> (8 * w))});
        w++;
      end
      if (!frz && c >= 2 + d && c < 2 + d + n) check("mem_a", mem_a, addr + 32'(c - 2 - d));
      if (!stall_req) begin
        done = 1;
        check("done_c", 32'(c), 32'(exp_done));
        check("wb_d", wb_rd_data, ev);
        check("wb_a", {27'd0, wb_rd_addr}, {27'd0, rd});
        check("wb_en", {31'd0, wb_rd_enable}, {31'd0, ld ? en : 1'b0});
        check("req_done", {31'd0, mem_req}, 0);
      end else check("bubble", {31'd0, wb_rd_enable}, 0);
      c++;
    end
    check("timeout", {31'd0, done}, 1);
    check("n_wr", 32'(w), ld ? 0 : 32'(n));
    rdy = 1;
  endtask

  initial begin
    logic [7:0] ops [9];
    logic [7:0] op;
    logic [31:0] a;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADD};
    rst = 1; rdy = 1;
    drive(OP_NOP, SEL_NOP, 32'hdeadbeef, 5'd3, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall_req}, 0);
    check("rst_req", {31'd0, mem_req}, 0);
    check("rst_a", mem_a, 0);
    check("rst_wr", {31'd0, mem_wr}, 0);
    check("rst_wbd", wb_rd_data, 0);
    check("rst_wben", {31'd0, wb_rd_enable}, 0);
    rst = 0;
    run_alu(32'h12345678, 5'd5, 1'b1);
    run_mem(OP_SW, 32'h12345678, 32'h100, 5'd0, 1'b0, 0, 0);
    run_mem(OP_LW, 32'h0, 32'h100, 5'd7, 1'b1, 0, 0);
    run_mem(OP_SB, 32'h80, 32'h200, 5'd0, 1'b0, 0, 0);
    run_mem(OP_LB, 32'h0, 32'h200, 5'd8, 1'b1, 0, 0);
    run_mem(OP_LBU, 32'h0, 32'h200, 5'd9, 1'b1, 0, 0);
    run_mem(OP_SH, 32'hfffe, 32'h202, 5'd0, 1'b0, 0, 0);
    run_mem(OP_LH, 32'h0, 32'h202, 5'd10, 1'b1, 0, 0);
    run_mem(OP_SH, 32'haabbccdd, 32'h300, 5'd0, 1'b1, 3, 0);
    run_mem(OP_LW, 32'h0, 32'h300, 5'd0, 1'b1, 1, 0);
    gnt_delay = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(OP_LW, SEL_MEM, 32'h0, 5'd4, 1'b1, 32'h100);
      if (c == 4) rst = 1;
      #1;
    end
    check("midrst_stall", {31'd0, stall_req}, 0);
    @(negedge clk);
    rst = 0;
    drive(OP_NOP, SEL_NOP, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    check("postrst_stall", {31'd0, stall_req}, 0);
    check("postrst_req", {31'd0, mem_req}, 0);
    check("postrst_a", mem_a, 0);
    run_mem(OP_LW, 32'h0, 32'h100, 5'd4, 1'b1, 0, 0);
    run_mem(OP_SW, 32'hcafef00d, 32'h400, 5'd0, 1'b0, 1, 1);
    run_mem(OP_LW, 32'h0, 32'h400, 5'd6, 1'b1, 0, 0);
    run_mem(OP_LW, 32'h0, 32'hfffffffe, 5'd0, 1'b1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = $urandom_range(0, 3) == 0 ? 32'hfffffffc + 32'($urandom_range(0, 3)) : 32'h1000 + 32'($urandom_range(0, 31));
      if (op == OP_ADD) run_alu($urandom, 5'($urandom), 1'($urandom));
      else run_mem(op, $urandom, a, 5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
